penc42: RTL and testbench

PENC42 -- requirements
Module: penc42

---
 rtl/penc42_pkg.sv | 10 +
 rtl/penc42_core.sv | 20 ++
 rtl/penc42.sv | 39 +++
 tb/tb_penc42.sv | 127 ++++++++++++
 4 files changed

// File: rtl/penc42_pkg.sv
// Shared widths and types for the 4-to-2 priority encoder.
package penc42_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 2;

  typedef logic [IN_W-1:0]  req_t;
  typedef logic [OUT_W-1:0] idx_t;

endpackage

// File: rtl/penc42_core.sv
// Combinational strict-priority encoder: highest set bit of y wins.
module penc42_core
  import penc42_pkg::*;
(
  input  req_t y,
  output idx_t a,
  output logic valid
);

  always_comb begin
    valid = |y;
    casez (y)
      4'b1???: a = 2'd3;
      4'b01??: a = 2'd2;
      4'b001?: a = 2'd1;
      default: a = 2'd0;
    endcase
  end

endmodule

// File: rtl/penc42.sv
// Registered priority encoder: one-cycle latency, async active-low clear.
module penc42
  import penc42_pkg::*;
#(
  parameter int IN_W  = penc42_pkg::IN_W,
  parameter int OUT_W = penc42_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  y,
  output logic [OUT_W-1:0] a,
  output logic             valid
);

  // The encoder table is fixed at 4 requests; reject other widths at elaboration.
  if (IN_W != 4 || OUT_W != 2) begin : g_width_check
    $error("penc42 supports only IN_W=4, OUT_W=2");
  end

  idx_t a_nxt;
  logic valid_nxt;

  penc42_core u_core (
    .y     (y),
    .a     (a_nxt),
    .valid (valid_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      valid <= 1'b0;
    end else begin
      a     <= a_nxt;
      valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_penc42.sv
// Self-checking bench for penc42: behavioural model plus directed literal checks.
module tb_penc42;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] y     = 4'b0000;
  logic [1:0] a;
  logic       valid;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0] exp_a = 2'd0;
  logic       exp_v = 1'b0;

  penc42 #(.IN_W(4), .OUT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (y),
    .a     (a),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Index of the highest set bit, searched from the top down.
  function automatic logic [1:0] ref_idx(input logic [3:0] v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [1:0] act_a, input logic act_v,
                       input logic [1:0] req_a, input logic req_v);
    n_total++;
    if (act_a === req_a && act_v === req_v)
      n_pass++;
    else
      $display("FAIL %s: got a=%b valid=%b, want a=%b valid=%b at %0t",
               name, act_a, act_v, req_a, req_v, $time);
  endtask

  // Model: outputs are the encoding of y as seen at the last edge, or zero under reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a = 2'd0;
      exp_v = 1'b0;
    end else begin
      exp_a = ref_idx(y);
      exp_v = (y != 4'b0000);
    end
  end

  always @(negedge clk) check("model", a, valid, exp_a, exp_v);

  task automatic step(input logic [3:0] v, input string name,
                      input logic [1:0] ea, input logic ev);
    y = v;
    @(posedge clk);
    #1;
    check(name, a, valid, ea, ev);
  endtask

  initial begin
    // Reset held with a high-priority request present.
    y = 4'b1000;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold", a, valid, 2'd0, 1'b0);
    end
    rst_n = 1'b1;
    step(4'b1000, "rst_release", 2'd3, 1'b1);

    step(4'b0001, "onehot0", 2'd0, 1'b1);
    step(4'b0010, "onehot1", 2'd1, 1'b1);
    step(4'b0100, "onehot2", 2'd2, 1'b1);
    step(4'b1000, "onehot3", 2'd3, 1'b1);

    step(4'b0101, "prio_0101", 2'd2, 1'b1);
    step(4'b0011, "prio_0011", 2'd1, 1'b1);
    step(4'b1111, "prio_1111", 2'd3, 1'b1);
    step(4'b0110, "prio_0110", 2'd2, 1'b1);

    step(4'b0000, "zero", 2'd0, 1'b0);
    step(4'b0001, "zero_then_one", 2'd0, 1'b1);

    // Outputs must not follow y between edges.
    step(4'b1000, "hold_load", 2'd3, 1'b1);
    y = 4'b0000;
    #2;
    check("hold_between_edges", a, valid, 2'd3, 1'b1);

    for (int v = 0; v < 16; v++)
      step(4'(v), "exhaustive", ref_idx(4'(v)), (v != 0));

    // Asynchronous clear mid-cycle while a=11.
    step(4'b1100, "async_pre", 2'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", a, valid, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("async_held", a, valid, 2'd0, 1'b0);
    rst_n = 1'b1;
    step(4'b0010, "async_after", 2'd1, 1'b1);

    // Random traffic with occasional short reset pulses away from clock edges.
    for (int n = 0; n < 300; n++) begin
      y = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
